qpp_read_addr_gen: RTL and testbench

// - Read-side address generator for the turbo interleaver buffer. Writes fill the buffer in

---
 rtl/qpp_read_addr_gen_if.sv | 24 ++
 rtl/qpp_read_addr_gen.sv | 108 ++++++++++
 tb/tb_qpp_read_addr_gen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/qpp_read_addr_gen_if.sv
// Valid/ready read-address stream of the QPP interleaver read-side address generator.
interface qpp_read_addr_gen_if #(
    parameter int ADDR_W = 13
);
    logic              start;
    logic              block_size;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              rd_last;
    logic [ADDR_W-1:0] rd_index;
    logic              busy;
    logic              done;

    modport master (
        output start, block_size, rd_ready,
        input  rd_addr, rd_valid, rd_last, rd_index, busy, done
    );

    modport slave (
        input  start, block_size, rd_ready,
        output rd_addr, rd_valid, rd_last, rd_index, busy, done
    );
endinterface

// File: rtl/qpp_read_addr_gen.sv
// QPP interleaver read address generator: pi(i)=(F1*i+F2*i^2) mod K computed
// recursively with modular adds, streamed out on a valid/ready port.
module qpp_read_addr_gen #(
    parameter int ADDR_W   = 13,
    parameter int K_SMALL  = 1056,
    parameter int F1_SMALL = 17,
    parameter int F2_SMALL = 66,
    parameter int K_LARGE  = 6144,
    parameter int F1_LARGE = 263,
    parameter int F2_LARGE = 480
) (
    input  logic                 clk,
    input  logic                 reset,
    qpp_read_addr_gen_if.slave   bus
);
    // Per-block constants: first increment g0=(F1+F2) mod K and the g step 2*F2 mod K.
    localparam logic [ADDR_W-1:0] K_S  = ADDR_W'(K_SMALL);
    localparam logic [ADDR_W-1:0] G0_S = ADDR_W'((F1_SMALL + F2_SMALL) % K_SMALL);
    localparam logic [ADDR_W-1:0] D_S  = ADDR_W'((2 * F2_SMALL) % K_SMALL);
    localparam logic [ADDR_W-1:0] K_L  = ADDR_W'(K_LARGE);
    localparam logic [ADDR_W-1:0] G0_L = ADDR_W'((F1_LARGE + F2_LARGE) % K_LARGE);
    localparam logic [ADDR_W-1:0] D_L  = ADDR_W'((2 * F2_LARGE) % K_LARGE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] k_r, d_r, g_r, pi_r, i_r;
    logic              valid_r, last_r, busy_r, done_r;

    // Both operands are < k, so one conditional subtract keeps the result < k.
    function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W-1:0] k);
        logic [ADDR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k})
            s = s - {1'b0, k};
        return s[ADDR_W-1:0];
    endfunction

    logic              hs;
    logic [ADDR_W-1:0] i_nxt, k_m1;

    assign hs    = valid_r & bus.rd_ready;
    assign i_nxt = i_r + ADDR_W'(1);
    assign k_m1  = k_r - ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            k_r     <= '0;
            d_r     <= '0;
            g_r     <= '0;
            pi_r    <= '0;
            i_r     <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        k_r     <= bus.block_size ? K_L  : K_S;
                        d_r     <= bus.block_size ? D_L  : D_S;
                        g_r     <= bus.block_size ? G0_L : G0_S;
                        pi_r    <= '0;
                        i_r     <= '0;
                        valid_r <= 1'b1;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (last_r) begin
                            // Final address taken: pi/i stay put, pulse done next cycle.
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            pi_r   <= mod_add(pi_r, g_r, k_r);
                            g_r    <= mod_add(g_r, d_r, k_r);
                            i_r    <= i_nxt;
                            last_r <= (i_nxt == k_m1);
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_addr  = pi_r;
    assign bus.rd_index = i_r;
    assign bus.rd_valid = valid_r;
    assign bus.rd_last  = last_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_qpp_read_addr_gen.sv
// Scoreboard bench for qpp_read_addr_gen: expected pi(i) from the closed-form QPP
// polynomial, compared at every handshake, plus stall, start-ignore and reset scenarios.
module tb_qpp_read_addr_gen;
    localparam int AW = 13;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qpp_read_addr_gen_if #(.ADDR_W(AW)) bus();

    qpp_read_addr_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int addr;
        int idx;
        bit last;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   k_cur, f1_cur, f2_cur;
    int   seen[8192];
    int   hs_cnt, done_cnt, range_bad, cap_last;
    int   cap[5];
    bit   prev_stall;
    int   prev_addr, prev_idx;
    bit   stall_en, junk_en;

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int pi_of(input int k, input int f1, input int f2, input int i);
        longint v;
        v = (longint'(f1) * i + longint'(f2) * i * i) % k;
        return int'(v);
    endfunction

    // One cycle: observe on the falling edge, drive just after the rising edge.
    task automatic tick();
        bit   hs;
        exp_t e;
        @(negedge clk);
        if (prev_stall && bus.rd_valid && !reset) begin
            chk("hold_addr", bus.rd_addr, prev_addr);
            chk("hold_idx", bus.rd_index, prev_idx);
        end
        prev_stall = bus.rd_valid && !bus.rd_ready && !reset;
        prev_addr  = int'(bus.rd_addr);
        prev_idx   = int'(bus.rd_index);
        hs = bus.rd_valid && bus.rd_ready && !reset;
        if (hs) begin
            if (q.size() == 0) begin
                chk("q_underflow", 1, 0);
            end else begin
                e = q.pop_front();
                chk("addr", bus.rd_addr, e.addr);
                chk("index", bus.rd_index, e.idx);
                chk("last", bus.rd_last, e.last);
            end
            if (int'(bus.rd_addr) < k_cur) seen[bus.rd_addr]++;
            else range_bad++;
            if (int'(bus.rd_index) < 5) cap[bus.rd_index] = int'(bus.rd_addr);
            if (int'(bus.rd_index) == k_cur - 1) cap_last = int'(bus.rd_addr);
            hs_cnt++;
        end
        if (bus.done) done_cnt++;
        @(posedge clk);
        #1;
        bus.rd_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (junk_en && bus.busy) begin
            bus.start      = 1'($urandom_range(0, 1));
            bus.block_size = 1'($urandom_range(0, 1));
        end else begin
            bus.start = 1'b0;
        end
    endtask

    task automatic prep(input int bs);
        exp_t e;
        k_cur  = bs ? 6144 : 1056;
        f1_cur = bs ? 263 : 17;
        f2_cur = bs ? 480 : 66;
        q.delete();
        for (int i = 0; i < k_cur; i++) begin
            e.addr = pi_of(k_cur, f1_cur, f2_cur, i);
            e.idx  = i;
            e.last = (i == k_cur - 1);
            q.push_back(e);
        end
        for (int i = 0; i < 8192; i++) seen[i] = 0;
        for (int i = 0; i < 5; i++) cap[i] = -1;
        cap_last   = -1;
        hs_cnt     = 0;
        done_cnt   = 0;
        range_bad  = 0;
        prev_stall = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted start.
    task automatic launch(input int bs);
        bus.block_size = 1'(bs);
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.rd_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        chk("lat_valid", bus.rd_valid, 1);
        chk("lat_addr", bus.rd_addr, 0);
        chk("lat_busy", bus.busy, 1);
    endtask

    task automatic run_block(input int bs, input bit stall, input bit junk);
        int cyc;
        int bad;
        stall_en = stall;
        junk_en  = junk;
        prep(bs);
        launch(bs);
        cyc = 0;
        while (done_cnt == 0 && cyc < 6 * k_cur + 50) begin
            tick();
            cyc++;
        end
        chk("done_seen", done_cnt, 1);
        if (!stall) chk("cycles", cyc, k_cur + 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_valid", bus.rd_valid, 0);
        chk("idle_done", bus.done, 0);
        junk_en = 1'b0;
        tick();
        tick();
        chk("done_once", done_cnt, 1);
        chk("handshakes", hs_cnt, k_cur);
        chk("q_left", q.size(), 0);
        chk("range", range_bad, 0);
        bad = 0;
        for (int i = 0; i < k_cur; i++) if (seen[i] != 1) bad++;
        chk("perm", bad, 0);
        stall_en  = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        int cyc;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.block_size = 1'b0;
        bus.rd_ready   = 1'b0;
        stall_en       = 1'b0;
        junk_en        = 1'b0;
        k_cur          = 1056;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", bus.rd_addr, 0);
        chk("rst_index", bus.rd_index, 0);
        chk("rst_valid", bus.rd_valid, 0);
        chk("rst_last", bus.rd_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);

        // reset outranks a simultaneous start
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_prio_busy", bus.busy, 0);
        chk("rst_prio_valid", bus.rd_valid, 0);
        bus.start = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        #1;

        run_block(0, 1'b0, 1'b0);
        chk("s_pi0", cap[0], 0);
        chk("s_pi1", cap[1], 83);
        chk("s_pi2", cap[2], 298);
        chk("s_pi3", cap[3], 645);
        chk("s_pi4", cap[4], 68);
        chk("s_last", cap_last, 49);

        run_block(1, 1'b0, 1'b0);
        chk("l_pi1", cap[1], 743);
        chk("l_pi2", cap[2], 2446);
        chk("l_pi3", cap[3], 5109);
        chk("l_pi4", cap[4], 2588);
        chk("l_last", cap_last, 217);

        run_block(0, 1'b1, 1'b1);
        run_block(1, 1'b1, 1'b1);

        // reset in the middle of a small block
        prep(0);
        launch(0);
        cyc = 0;
        while (int'(bus.rd_index) != 500 && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk("reach_500", bus.rd_index, 500);
        reset = 1'b1;
        tick();
        chk("mid_rst_addr", bus.rd_addr, 0);
        chk("mid_rst_index", bus.rd_index, 0);
        chk("mid_rst_valid", bus.rd_valid, 0);
        chk("mid_rst_last", bus.rd_last, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        reset = 1'b0;
        repeat (3) tick();
        chk("mid_rst_no_done", done_cnt, 0);

        run_block(0, 1'b0, 1'b0);
        chk("restart_pi1", cap[1], 83);
        chk("restart_last", cap_last, 49);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
